// File: rtl/branch_comp_pkg.sv
// Shared definitions for the iterative branch comparator: RV32I branch funct3
// codes, FSM states and the taken-flag decode.
package branch_comp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    // Branch decision from the resolved compare; reserved encodings never take.
    function automatic logic taken_f(input logic [2:0] funct3, input logic eq, input logic lt);
        logic taken;
        case (funct3)
            F3_BEQ:            taken = eq;
            F3_BNE:            taken = ~eq;
            F3_BLT,  F3_BLTU:  taken = lt;
            F3_BGE,  F3_BGEU:  taken = ~lt;
            default:           taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/br_digit_cmp.sv
// Unsigned compare of one operand digit; the top walks digits MSB-first.
module br_digit_cmp #(
    parameter int unsigned DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             eq,
    output logic             lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/branch_comp_iter.sv
// Multi-cycle RV32I branch comparator: scans operands DIGIT bits per cycle,
// MSB-first, and presents eq/lt/taken behind a valid/ready handshake.
module branch_comp_iter
    import branch_comp_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIGIT      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic [2:0]       i_funct3,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_eq,
    output logic             o_br_lt,
    output logic             o_taken,
    output logic             o_illegal
);

    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NDIG-1:0][DIGIT-1:0]    a_q, a_d, b_q, b_d;
    logic [2:0]                    f3_q, f3_d;
    logic                          diff_q, diff_d;
    logic                          eq_q, eq_d, lt_q, lt_d;
    logic                          valid_q, valid_d;
    logic                          br_eq_q, br_eq_d, br_lt_q, br_lt_d;
    logic                          taken_q, taken_d, illegal_q, illegal_d;
    logic                          dig_eq, dig_lt;

    br_digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .eq (dig_eq),
        .lt (dig_lt)
    );

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        f3_d      = f3_q;
        diff_d    = diff_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        valid_d   = valid_q;
        br_eq_d   = br_eq_q;
        br_lt_d   = br_lt_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;

        if (i_flush) begin
            state_d   = IDLE;
            idx_d     = '0;
            valid_d   = 1'b0;
            br_eq_d   = 1'b0;
            br_lt_d   = 1'b0;
            taken_d   = 1'b0;
            illegal_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        state_d = SCAN;
                        idx_d   = IDX_LAST;
                        a_d     = i_rs1_data;
                        b_d     = i_rs2_data;
                        // Flipping the sign bits turns two's-complement order into unsigned order
                        a_d[NDIG-1][DIGIT-1] = i_rs1_data[WIDTH-1] ^ ~i_funct3[1];
                        b_d[NDIG-1][DIGIT-1] = i_rs2_data[WIDTH-1] ^ ~i_funct3[1];
                        f3_d    = i_funct3;
                        diff_d  = 1'b0;
                        eq_d    = 1'b1;
                        lt_d    = 1'b0;
                    end
                end
                SCAN: begin
                    // Only the most significant differing digit decides the order
                    if (!dig_eq && !diff_q) begin
                        diff_d = 1'b1;
                        eq_d   = 1'b0;
                        lt_d   = dig_lt;
                    end
                    if ((!dig_eq && EARLY_EXIT) || (idx_q == '0)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                DONE: begin
                    valid_d   = 1'b1;
                    br_eq_d   = eq_q;
                    br_lt_d   = lt_q;
                    taken_d   = taken_f(f3_q, eq_q, lt_q);
                    illegal_d = (f3_q[2:1] == 2'b01);
                    if (valid_q && i_ready) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            f3_q      <= '0;
            diff_q    <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            valid_q   <= 1'b0;
            br_eq_q   <= 1'b0;
            br_lt_q   <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            f3_q      <= f3_d;
            diff_q    <= diff_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            valid_q   <= valid_d;
            br_eq_q   <= br_eq_d;
            br_lt_q   <= br_lt_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_valid   = valid_q;
    assign o_br_eq   = br_eq_q;
    assign o_br_lt   = br_lt_q;
    assign o_taken   = taken_q;
    assign o_illegal = illegal_q;

endmodule
